// File: rtl/music_sequencer.sv
// Melody sequencer for the PWM tone generator. Steps through a synchronous
// note ROM and lets a one-shot sound effect pre-empt the melody. When the
// effect ends, the melody resumes from the exact point where it paused.
//
// state | meaning
// IDLE  | silent, waiting for start or a sound-effect request
// FETCH | ROM address presented, waiting one cycle for read data
// LOAD  | capture note or end marker from rom_data
// PLAY  | hold the current note for its beat count
// SFX   | sound effect sounding, melody context parked in sv_* registers
module music_sequencer #(
   parameter int unsigned BEAT_CYC = 12_500_000,
   parameter int unsigned ADDR_W   = 8,
   parameter logic [9:0]  DUTY_ON  = 10'd512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [35:0]       rom_data,
   input  logic              sfx_req,
   input  logic [27:0]       sfx_freq,
   input  logic [7:0]        sfx_beats,
   output logic              sfx_ack,
   output logic [27:0]       freq,
   output logic [9:0]        duty,
   output logic              playing,
   output logic              sfx_busy
);

   localparam int unsigned       TICK_W      = $clog2(BEAT_CYC);
   localparam logic [TICK_W-1:0] TICK_MAX    = TICK_W'(BEAT_CYC - 1);
   localparam logic [27:0]       FREQ_SILENT = 28'd1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_SFX} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [7:0]          beat_cnt, beat_nxt;
   logic [TICK_W-1:0]   tick, tick_nxt;
   logic [27:0]         freq_nxt;
   logic [9:0]          duty_nxt;
   logic                ack_nxt;

   logic                sv_valid, sv_valid_nxt;
   logic                sv_fetch, sv_fetch_nxt;
   logic [7:0]          sv_beat, sv_beat_nxt;
   logic [TICK_W-1:0]   sv_tick, sv_tick_nxt;
   logic [27:0]         sv_freq, sv_freq_nxt;
   logic [9:0]          sv_duty, sv_duty_nxt;

   logic [7:0]          sfx_left, sfx_left_nxt;
   logic [TICK_W-1:0]   sfx_tick, sfx_tick_nxt;

   logic [TICK_W-1:0]   adv_tick;
   logic [7:0]          adv_beat;
   logic                adv_done;
   logic                sfx_done;
   logic                take_sfx;

   logic [27:0]         note_freq;
   logic [7:0]          note_beats;

   assign note_freq  = rom_data[35:8];
   assign note_beats = rom_data[7:0];

   assign sfx_busy = (state == S_SFX);
   assign playing  = (state == S_FETCH) || (state == S_LOAD) || (state == S_PLAY) ||
                     ((state == S_SFX) && sv_valid);

   // One PLAY cycle of progress; an accepted effect parks this advanced
   // position, so the cycle that saw the request still counts toward the note.
   always_comb begin
      adv_tick = tick + 1'b1;
      adv_beat = beat_cnt;
      adv_done = 1'b0;
      if (tick == TICK_MAX) begin
         adv_tick = '0;
         adv_beat = beat_cnt - 8'd1;
         adv_done = (beat_cnt == 8'd1);
      end
      sfx_done = (sfx_left == 8'd0) || ((sfx_left == 8'd1) && (sfx_tick == TICK_MAX));
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt    = state;
      addr_nxt     = rom_addr;
      beat_nxt     = beat_cnt;
      tick_nxt     = tick;
      freq_nxt     = freq;
      duty_nxt     = duty;
      ack_nxt      = 1'b0;
      sv_valid_nxt = sv_valid;
      sv_fetch_nxt = sv_fetch;
      sv_beat_nxt  = sv_beat;
      sv_tick_nxt  = sv_tick;
      sv_freq_nxt  = sv_freq;
      sv_duty_nxt  = sv_duty;
      sfx_left_nxt = sfx_left;
      sfx_tick_nxt = sfx_tick;
      take_sfx     = 1'b0;

      if (stop) begin
         state_nxt    = S_IDLE;
         addr_nxt     = '0;
         freq_nxt     = FREQ_SILENT;
         duty_nxt     = '0;
         sv_valid_nxt = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt = S_FETCH;
                  addr_nxt  = '0;
               end else if (sfx_req) begin
                  take_sfx     = 1'b1;
                  sv_valid_nxt = 1'b0;
               end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
               if (note_beats == 8'd0) begin
                  if (loop_en && (rom_addr != '0)) begin
                     state_nxt = S_FETCH;
                     addr_nxt  = '0;
                  end else begin
                     state_nxt = S_IDLE;
                     freq_nxt  = FREQ_SILENT;
                     duty_nxt  = '0;
                  end
               end else begin
                  state_nxt = S_PLAY;
                  beat_nxt  = note_beats;
                  tick_nxt  = '0;
                  if (note_freq == 28'd0) begin
                     freq_nxt = FREQ_SILENT;
                     duty_nxt = '0;
                  end else begin
                     freq_nxt = note_freq;
                     duty_nxt = DUTY_ON;
                  end
               end
            end
            S_PLAY: begin
               tick_nxt = adv_tick;
               beat_nxt = adv_beat;
               if (adv_done) begin
                  addr_nxt = rom_addr + 1'b1;
               end
               if (sfx_req) begin
                  // rom_addr is not touched in SFX, so it needs no copy.
                  take_sfx     = 1'b1;
                  sv_valid_nxt = 1'b1;
                  sv_fetch_nxt = adv_done;
                  sv_beat_nxt  = adv_beat;
                  sv_tick_nxt  = adv_tick;
                  sv_freq_nxt  = freq;
                  sv_duty_nxt  = duty;
               end else if (adv_done) begin
                  state_nxt = S_FETCH;
               end
            end
            S_SFX: begin
               if (sfx_tick == TICK_MAX) begin
                  sfx_tick_nxt = '0;
                  sfx_left_nxt = sfx_left - 8'd1;
               end else begin
                  sfx_tick_nxt = sfx_tick + 1'b1;
               end
               if (sfx_done) begin
                  if (sv_valid) begin
                     state_nxt    = sv_fetch ? S_FETCH : S_PLAY;
                     beat_nxt     = sv_beat;
                     tick_nxt     = sv_tick;
                     freq_nxt     = sv_freq;
                     duty_nxt     = sv_duty;
                     sv_valid_nxt = 1'b0;
                  end else begin
                     state_nxt = S_IDLE;
                     freq_nxt  = FREQ_SILENT;
                     duty_nxt  = '0;
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      // A zero-beat effect is acknowledged but leaves the current outputs alone.
      if (take_sfx) begin
         state_nxt    = S_SFX;
         ack_nxt      = 1'b1;
         sfx_left_nxt = sfx_beats;
         sfx_tick_nxt = '0;
         if (sfx_beats != 8'd0) begin
            freq_nxt = (sfx_freq == 28'd0) ? FREQ_SILENT : sfx_freq;
            duty_nxt = DUTY_ON;
         end
      end
   end

   // State, outputs and parked melody context.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rom_addr <= '0;
         beat_cnt <= '0;
         tick     <= '0;
         freq     <= FREQ_SILENT;
         duty     <= '0;
         sfx_ack  <= 1'b0;
         sv_valid <= 1'b0;
         sv_fetch <= 1'b0;
         sv_beat  <= '0;
         sv_tick  <= '0;
         sv_freq  <= FREQ_SILENT;
         sv_duty  <= '0;
         sfx_left <= '0;
         sfx_tick <= '0;
      end else begin
         state    <= state_nxt;
         rom_addr <= addr_nxt;
         beat_cnt <= beat_nxt;
         tick     <= tick_nxt;
         freq     <= freq_nxt;
         duty     <= duty_nxt;
         sfx_ack  <= ack_nxt;
         sv_valid <= sv_valid_nxt;
         sv_fetch <= sv_fetch_nxt;
         sv_beat  <= sv_beat_nxt;
         sv_tick  <= sv_tick_nxt;
         sv_freq  <= sv_freq_nxt;
         sv_duty  <= sv_duty_nxt;
         sfx_left <= sfx_left_nxt;
         sfx_tick <= sfx_tick_nxt;
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer. The reference model tracks each note and effect
// as a count of remaining cycles. Directed scenarios come first, followed by
// randomized melodies and effect requests.
module tb_music_sequencer;

   localparam int          BC  = 4;
   localparam int          AW  = 4;
   localparam logic [9:0]  DON = 10'd512;

   logic           clk = 1'b0;
   logic           reset, start, stop, loop_en, sfx_req;
   logic [AW-1:0]  rom_addr;
   logic [35:0]    rom_data;
   logic [27:0]    sfx_freq;
   logic [7:0]     sfx_beats;
   logic           sfx_ack, playing, sfx_busy;
   logic [27:0]    freq;
   logic [9:0]     duty;

   logic [35:0]    rom [16];
   int             checks = 0;
   int             errors = 0;

   // reference model state
   bit             m_run, s_on, s_tone, e_ack;
   int             m_gap, m_left, s_left;
   logic [AW-1:0]  m_addr;
   logic [27:0]    m_f, s_f;
   logic [9:0]     m_d;

   music_sequencer #(.BEAT_CYC(BC), .ADDR_W(AW), .DUTY_ON(DON)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .sfx_req(sfx_req),
      .sfx_freq(sfx_freq), .sfx_beats(sfx_beats), .sfx_ack(sfx_ack),
      .freq(freq), .duty(duty), .playing(playing), .sfx_busy(sfx_busy)
   );

   always #5 clk = ~clk;

   // synchronous note ROM
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_run = 0; s_on = 0; s_tone = 0; e_ack = 0;
      m_gap = 0; m_left = 0; s_left = 0;
      m_addr = '0; m_f = 28'd1; m_d = '0; s_f = 28'd1;
   endfunction

   function automatic void take_sfx();
      e_ack  = 1;
      s_on   = 1;
      s_tone = (sfx_beats != 8'd0);
      s_left = (sfx_beats == 8'd0) ? 1 : int'(sfx_beats) * BC;
      s_f    = (sfx_freq == 28'd0) ? 28'd1 : sfx_freq;
   endfunction

   // One clock edge of the reference model, using the inputs seen at that edge.
   function automatic void model_step();
      logic [7:0]  b;
      logic [27:0] f;
      e_ack = 0;
      if (stop) begin
         m_run = 0; s_on = 0; m_addr = '0; m_f = 28'd1; m_d = '0;
         return;
      end
      if (s_on) begin
         s_left--;
         if (s_left == 0) s_on = 0;
         return;
      end
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_addr = '0; m_gap = 2;
         end else if (sfx_req) begin
            take_sfx();
         end
         return;
      end
      if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin
            b = rom[m_addr][7:0];
            f = rom[m_addr][35:8];
            if (b == 8'd0) begin
               if (loop_en && m_addr != '0) begin
                  m_addr = '0; m_gap = 2;
               end else begin
                  m_run = 0; m_f = 28'd1; m_d = '0;
               end
            end else begin
               m_left = int'(b) * BC;
               m_f    = (f == 28'd0) ? 28'd1 : f;
               m_d    = (f == 28'd0) ? 10'd0 : DON;
            end
         end
         return;
      end
      if (sfx_req) take_sfx();
      m_left--;
      if (m_left == 0) begin
         m_addr = m_addr + 1'b1;
         m_gap  = 2;
      end
   endfunction

   task automatic compare_outputs();
      logic [27:0] ef;
      logic [9:0]  ed;
      ef = (s_on && s_tone) ? s_f : m_f;
      ed = (s_on && s_tone) ? DON : m_d;
      chk("freq", 64'(freq), 64'(ef));
      chk("duty", 64'(duty), 64'(ed));
      chk("rom_addr", 64'(rom_addr), 64'(m_addr));
      chk("sfx_ack", 64'(sfx_ack), 64'(e_ack));
      chk("playing", 64'(playing), 64'(m_run));
      chk("sfx_busy", 64'(sfx_busy), 64'(s_on));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
   endtask

   // Cycles (including the current one) for which freq stays at f.
   task automatic run_len(input logic [27:0] f, output int n);
      n = 0;
      while (freq == f && n < 200) begin
         n++;
         step();
      end
   endtask

   task automatic wait_freq(input string tag, input logic [27:0] f);
      int n;
      n = 0;
      while (freq != f && n < 100) begin
         n++;
         step();
      end
      chk(tag, 64'(freq == f), 64'd1);
   endtask

   task automatic rom_melody();
      for (int i = 0; i < 16; i++) rom[i] = 36'd0;
      rom[0] = {28'd440, 8'd2};
      rom[1] = {28'd0,   8'd1};
      rom[2] = {28'd880, 8'd1};
      rom[3] = {28'd0,   8'd0};
   endtask

   task automatic rom_random();
      int          endpos;
      logic [27:0] f;
      logic [7:0]  b;
      endpos = $urandom_range(1, 20);
      for (int i = 0; i < 16; i++) begin
         f = ($urandom_range(0, 3) == 0) ? 28'd0 : 28'($urandom_range(1, 20000));
         b = 8'($urandom_range(1, 3));
         rom[i] = (i == endpos) ? {f, 8'd0} : {f, b};
      end
   endtask

   task automatic go_idle();
      stop = 1; step(); stop = 0; step();
   endtask

   task automatic pulse_start();
      start = 1; step(); start = 0;
   endtask

   initial begin
      int n, acks;
      bit wrapped;
      logic [AW-1:0] prev;

      reset = 1; start = 0; stop = 0; loop_en = 0; sfx_req = 0;
      sfx_freq = '0; sfx_beats = '0;
      rom_melody();
      @(negedge clk);
      @(negedge clk);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);
      chk("rst_freq", 64'(freq), 64'd1);
      chk("rst_duty", 64'(duty), 64'd0);
      chk("rst_ack", 64'(sfx_ack), 64'd0);
      chk("rst_playing", 64'(playing), 64'd0);
      chk("rst_busy", 64'(sfx_busy), 64'd0);
      reset = 0;
      model_reset();
      step();

      // basic melody: 440 x2 beats, rest x1, 880 x1, end
      pulse_start();
      step(); step();
      chk("a_first_440", 64'(freq), 64'd440);
      run_len(28'd440, n); chk("a_440_len", 64'(n), 64'd10);
      run_len(28'd1, n);   chk("a_rest_len", 64'(n), 64'd6);
      run_len(28'd880, n); chk("a_880_len", 64'(n), 64'd6);
      chk("a_end_freq", 64'(freq), 64'd1);
      chk("a_end_playing", 64'(playing), 64'd0);

      // loop back to address 0, then stop+start together
      loop_en = 1;
      pulse_start();
      step(); step();
      run_len(28'd440, n); chk("l_440_len", 64'(n), 64'd10);
      run_len(28'd1, n);   chk("l_rest_len", 64'(n), 64'd6);
      run_len(28'd880, n); chk("l_880_len", 64'(n), 64'd8);
      chk("l_replay_freq", 64'(freq), 64'd440);
      chk("l_replay_addr", 64'(rom_addr), 64'd0);
      step(); step();
      stop = 1; start = 1; step(); stop = 0; start = 0;
      chk("ss_freq", 64'(freq), 64'd1);
      chk("ss_duty", 64'(duty), 64'd0);
      chk("ss_addr", 64'(rom_addr), 64'd0);
      step(); step();
      chk("ss_playing", 64'(playing), 64'd0);

      // end marker at address 0 ends immediately even with loop_en
      rom[0] = 36'd0;
      pulse_start(); step(); step();
      chk("e0_playing", 64'(playing), 64'd0);
      loop_en = 0;

      // effect pre-empts the 440 note after 3 played cycles; 5 remain
      rom_melody();
      pulse_start(); step(); step();
      step(); step();
      sfx_freq = 28'd1000; sfx_beats = 8'd2; sfx_req = 1;
      step();
      sfx_req = 0;
      chk("sfx_ack", 64'(sfx_ack), 64'd1);
      chk("sfx_busy_on", 64'(sfx_busy), 64'd1);
      run_len(28'd1000, n); chk("sfx_len", 64'(n), 64'd8);
      run_len(28'd440, n);  chk("sfx_resume_len", 64'(n), 64'd7);
      go_idle();

      // request held through FETCH/LOAD and SFX: single ack, sfx_freq 0 -> 1
      rom[0] = {28'd440, 8'd1};
      rom[1] = {28'd880, 8'd1};
      rom[2] = 36'd0;
      pulse_start(); step(); step();
      step(); step(); step(); step();
      sfx_freq = 28'd0; sfx_beats = 8'd1; sfx_req = 1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (sfx_ack) begin
            acks++;
            chk("sfx0_freq", 64'(freq), 64'd1);
            chk("sfx0_duty", 64'(duty), 64'(DON));
         end
      end
      sfx_req = 0;
      chk("held_acks", 64'(acks), 64'd1);
      step();
      chk("held_resume", 64'(freq), 64'd880);
      go_idle();

      // zero-beat effect: acked, no tone
      rom_melody();
      pulse_start(); step(); step(); step();
      sfx_freq = 28'd777; sfx_beats = 8'd0; sfx_req = 1;
      step();
      sfx_req = 0;
      chk("z_ack", 64'(sfx_ack), 64'd1);
      chk("z_freq", 64'(freq), 64'd440);
      wait_freq("z_reach_880", 28'd880);

      // asynchronous reset in the middle of an effect
      sfx_freq = 28'd3000; sfx_beats = 8'd3; sfx_req = 1;
      step();
      sfx_req = 0;
      step(); step();
      #2 reset = 1;
      #1;
      chk("ar_freq", 64'(freq), 64'd1);
      chk("ar_duty", 64'(duty), 64'd0);
      chk("ar_addr", 64'(rom_addr), 64'd0);
      chk("ar_busy", 64'(sfx_busy), 64'd0);
      chk("ar_playing", 64'(playing), 64'd0);
      chk("ar_ack", 64'(sfx_ack), 64'd0);
      @(negedge clk);
      reset = 0;
      model_reset();
      step();

      // 16 notes with no end marker: address wraps 15 -> 0
      for (int i = 0; i < 16; i++) rom[i] = {28'(100 + i), 8'd1};
      pulse_start();
      wrapped = 0;
      prev = rom_addr;
      for (int i = 0; i < 200 && !wrapped; i++) begin
         step();
         if (prev == 4'd15 && rom_addr == 4'd0) wrapped = 1;
         prev = rom_addr;
      end
      chk("wrap_seen", 64'(wrapped), 64'd1);
      chk("wrap_hold_freq", 64'(freq), 64'd115);
      go_idle();

      // randomized melodies, effects, stops and restarts
      for (int r = 0; r < 8; r++) begin
         go_idle();
         rom_random();
         loop_en = 1'($urandom_range(0, 1));
         pulse_start();
         for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 249) == 0);
            if (!sfx_req) begin
               if ($urandom_range(0, 24) == 0) begin
                  sfx_req   = 1;
                  sfx_freq  = ($urandom_range(0, 3) == 0) ? 28'd0 : 28'($urandom_range(1, 9000));
                  sfx_beats = 8'($urandom_range(0, 2));
               end
            end else if ($urandom_range(0, 2) == 0) begin
               sfx_req = 0;
            end
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            step();
         end
         start = 0; stop = 0; sfx_req = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
